twiddle_gen: RTL and testbench
==============================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 Parameter N_LOG2, default 4, log2 of FFT length N; legal range 3..12.
REQ-002 Parameter WIDTH, default 12, signed width of each output component.
REQ-003 Ports are clk and rst_n. There is one clock. Reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 addr  in  N_LOG2-1  twiddle index a, 0..N/2-1, for W_N^a.
REQ-007 addr_nd  in  1  addr is valid this cycle.
REQ-008 inverse  in  1  conjugate output (IFFT twiddle); sampled with addr_nd or start.
REQ-009 start  in  1  one-cycle pulse that launches a stage sequence.
REQ-010 stage  in  ceil(log2(N_LOG2))  DIT stage s, 0..N_LOG2-1; sampled on start.
REQ-011 tf_out  out  2*WIDTH  {re, im}; re is in the upper WIDTH bits; both are two's complement.
REQ-012 tf_nd  out  1  tf_out is valid this cycle.
REQ-013 busy  out  1  sequencer is active.
REQ-014 done  out  1  one-cycle pulse with the last sequenced tf_nd.

Function
REQ-015 Scale S = 2^(WIDTH-2). Quarter-wave table C[k] = round(S*cos(2*pi*k/N)), k = 0..N/4, fixed at elaboration.
REQ-016 For a < N/4: re = C[a], im = -C[N/4-a].
REQ-017 For a >= N/4, with b = a-N/4: re = -C[N/4-b], im = -C[b].
REQ-018 When inverse=1, im is negated after REQ-016/017; re is unchanged.
REQ-019 Pipeline:
- stage 1: fold the index and read the table.
- stage 2: apply sign and register.
- latency: exactly 2 cycles from an accepted index to tf_nd.
- throughput: one index per cycle.
REQ-020 tf_out holds its last value while tf_nd=0.
REQ-021 Sequencer states are IDLE and RUN.
- IDLE to RUN on start; the counter j is cleared and stage and inverse are latched.
REQ-022 In RUN, index j = 0..N/2-1 is issued once per cycle.
- Issued address = (j mod 2^s) << (N_LOG2-1-s).
- RUN returns to IDLE after j = N/2-1 is issued.
REQ-023 busy = 1 from the cycle after start until the last sequenced tf_nd.
- done is asserted with that last tf_nd.
REQ-024 start while busy is ignored.
REQ-025 addr_nd while busy is ignored. The sequencer has priority and produces no collision output.
REQ-026 start and addr_nd in the same idle cycle: start wins and addr is dropped.
REQ-027 Back-to-back start after done is legal. Start may be accepted in the same cycle that done is asserted.
REQ-028 Addresses at or above N/2 cannot occur; the port is N_LOG2-1 bits wide.

Reset
REQ-029 On rst_n=0 the following are cleared immediately: tf_out = 0, tf_nd = 0, busy = 0, done = 0, FSM = IDLE, j = 0, and pipeline valids.
REQ-030 Reset during RUN aborts the sequence. After reset release, no stale tf_nd or done is produced.
REQ-031 The first index is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro TWIDDLE_SEQ_EN:
- defined: the sequencer (REQ-021..027) is built.
- undefined: the sequencer is absent, start and stage are ignored, busy and done are tied to 0, and REQ-019 still holds.

Verification (N_LOG2=4, WIDTH=12)
REQ-033 Reset, then addr_nd with addr=1 -> two cycles later tf_nd=1, tf_out={946,-392}.
REQ-034 Stream addr 0..7, one per cycle, inverse=0 -> consecutive outputs:
- {1024,0}, {946,-392}, {724,-724}, {392,-946}
- {0,-1024}, {-392,-946}, {-724,-724}, {-946,-392}
REQ-035 addr=2 with inverse=1 -> {724,724}; addr=5 with inverse=1 -> {-392,946}.
REQ-036 start with stage=1 (TWIDDLE_SEQ_EN defined) -> 8 tf_nd outputs alternating {1024,0}, {0,-1024}. done on the 8th output. A second start mid-run has no effect.
REQ-037 start with stage=3, then rst_n low after 3 outputs -> all outputs 0 immediately. No further tf_nd or done until a new request.

Source files
------------

// File: rtl/twiddle_gen.sv
// twiddle_gen: FFT twiddle factor W_N^a = {re, im} from a quarter-wave cosine table, with optional DIT stage sequencer.
// Latency: 2 cycles from accepted index to tf_nd; one index per cycle.
// Backpressure: none; while busy the sequencer owns the pipe and addr_nd/start are dropped. Sequencer built only with TWIDDLE_SEQ_EN.
module twiddle_gen #(
  parameter int N_LOG2 = 4,
  parameter int WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_LOG2-2:0]           addr,
  input  logic                        addr_nd,
  input  logic                        inverse,
  input  logic                        start,
  input  logic [$clog2(N_LOG2)-1:0]   stage,
  output logic [2*WIDTH-1:0]          tf_out,
  output logic                        tf_nd,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);
  localparam int N  = 1 << N_LOG2;
  localparam int Q  = 1 << (N_LOG2 - 2);
  localparam logic [AW-1:0] QIDX = AW'(Q);

  // round(2^(WIDTH-2) * cos(2*pi*k/N)); argument stays within [0, pi/2] so the series converges fast
  function automatic int cos_q(input int k);
    real x, term, sum, scale;
    x     = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    scale = 2.0 ** (WIDTH - 2);
    term  = 1.0;
    sum   = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return $rtoi(sum * scale + 0.5);
  endfunction

  logic [WIDTH-1:0] ctab [0:Q];

  for (genvar k = 0; k <= Q; k++) begin : g_tab
    localparam int CV = cos_q(k);
    assign ctab[k] = WIDTH'(CV);
  end

  // pipe entry: one index per cycle from either the addr port or the sequencer
  logic          iss_vld;
  logic [AW-1:0] iss_addr;
  logic          iss_inv;

`ifdef TWIDDLE_SEQ_EN
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] j;
  logic [SW-1:0] stage_q;
  logic          inv_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          start_acc;
  logic          iss_last;
  logic [AW-1:0] seq_mask;
  logic [SW:0]   seq_shamt;
  logic [AW-1:0] seq_addr;

  // start is taken when idle, or in the done cycle so sequences can run back to back
  assign start_acc = start & (~busy_q | done_q);

  // sequencer address (j mod 2^s) << (N_LOG2-1-s) and pipe input arbitration
  always_comb begin
    seq_mask  = ~({AW{1'b1}} << stage_q);
    seq_shamt = (SW + 1)'(AW) - {1'b0, stage_q};
    seq_addr  = (j & seq_mask) << seq_shamt;
    iss_last  = 1'b0;
    if (state == RUN) begin
      iss_vld  = 1'b1;
      iss_addr = seq_addr;
      iss_inv  = inv_q;
      iss_last = (j == LAST);
    end else begin
      iss_vld  = addr_nd & ~busy_q & ~start;
      iss_addr = addr;
      iss_inv  = inverse;
    end
  end

  // sequencer FSM; busy/done are registered and track the last index through the 2-cycle pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      j       <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      last_q <= iss_last;
      done_q <= last_q;
      busy_q <= start_acc | (busy_q & ~done_q);
      case (state)
        IDLE: begin
          if (start_acc) begin
            state   <= RUN;
            j       <= '0;
            stage_q <= stage;
            inv_q   <= inverse;
          end
        end
        RUN: begin
          j <= j + 1'b1;
          if (j == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
`else
  logic unused_seq_in;

  // without the sequencer the pipe is fed straight from the addr port
  always_comb begin
    iss_vld  = addr_nd;
    iss_addr = addr;
    iss_inv  = inverse;
  end

  assign unused_seq_in = ^{start, stage};
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  logic          quad;
  logic [AW-1:0] b_idx;
  logic [AW-1:0] re_idx;
  logic [AW-1:0] im_idx;

  // fold the index onto the quarter-wave table: second quadrant mirrors re/im roles
  always_comb begin
    quad   = iss_addr[AW-1];
    b_idx  = {1'b0, iss_addr[AW-2:0]};
    re_idx = quad ? (QIDX - b_idx) : b_idx;
    im_idx = quad ? b_idx : (QIDX - b_idx);
  end

  logic             v1;
  logic [WIDTH-1:0] re_mag;
  logic [WIDTH-1:0] im_mag;
  logic             re_neg;
  logic             im_neg;

  // stage 1 registers table magnitudes and signs; stage 2 applies signs and holds tf_out between outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      re_mag <= '0;
      im_mag <= '0;
      re_neg <= 1'b0;
      im_neg <= 1'b0;
      tf_nd  <= 1'b0;
      tf_out <= '0;
    end else begin
      v1 <= iss_vld;
      if (iss_vld) begin
        re_mag <= ctab[re_idx];
        im_mag <= ctab[im_idx];
        re_neg <= quad;
        im_neg <= ~iss_inv;
      end
      tf_nd <= v1;
      if (v1) begin
        tf_out <= {(re_neg ? -re_mag : re_mag), (im_neg ? -im_mag : im_mag)};
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed checks of twiddle_gen at N_LOG2=4, WIDTH=12 against hand-computed twiddles.
// Latency: expects tf_nd two edges after an accepted index.
// Backpressure: sequencer scenarios run only when TWIDDLE_SEQ_EN is defined.
module tb_twiddle_gen;

  logic        clk;
  logic        rst_n;
  logic [2:0]  addr;
  logic        addr_nd;
  logic        inverse;
  logic        start;
  logic [1:0]  stage;
  logic [23:0] tf_out;
  logic        tf_nd;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] ev [8];
  logic        seen;

  twiddle_gen #(.N_LOG2(4), .WIDTH(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .addr_nd (addr_nd),
    .inverse (inverse),
    .start   (start),
    .stage   (stage),
    .tf_out  (tf_out),
    .tf_nd   (tf_nd),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] tf(input int re, input int im);
    return {12'(re), 12'(im)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    ev[0] = tf(1024, 0);
    ev[1] = tf(946, -392);
    ev[2] = tf(724, -724);
    ev[3] = tf(392, -946);
    ev[4] = tf(0, -1024);
    ev[5] = tf(-392, -946);
    ev[6] = tf(-724, -724);
    ev[7] = tf(-946, -392);

    rst_n = 1'b1; addr = '0; addr_nd = 1'b0; inverse = 1'b0; start = 1'b0; stage = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tf_out", 25'(tf_out), 25'(0));
    chk("rst_tf_nd", 25'(tf_nd), 25'(0));
    chk("rst_busy", 25'(busy), 25'(0));
    chk("rst_done", 25'(done), 25'(0));

    // first index on first edge after reset release
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; addr = 3'd1; addr_nd = 1'b1;
    tick;
    addr_nd = 1'b0;
    chk("lat1_nd", 25'(tf_nd), 25'(0));
    tick;
    chk("addr1", {tf_nd, tf_out}, {1'b1, tf(946, -392)});

    // stream 0..7 back to back
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin addr = 3'(k); addr_nd = 1'b1; end
      else addr_nd = 1'b0;
      tick;
      if (k >= 1) chk($sformatf("stream%0d", k - 1), {tf_nd, tf_out}, {1'b1, ev[k - 1]});
    end
    tick;
    chk("hold", {tf_nd, tf_out}, {1'b0, tf(-946, -392)});

    // inverse twiddles
    addr = 3'd2; addr_nd = 1'b1; inverse = 1'b1;
    tick;
    addr = 3'd5;
    tick;
    addr_nd = 1'b0; inverse = 1'b0;
    chk("inv_a2", {tf_nd, tf_out}, {1'b1, tf(724, 724)});
    tick;
    chk("inv_a5", {tf_nd, tf_out}, {1'b1, tf(-392, 946)});
    tick;

`ifdef TWIDDLE_SEQ_EN
    // stage 1 sequence with a stray start and addr_nd mid-run
    start = 1'b1; stage = 2'd1; inverse = 1'b0;
    tick;
    start = 1'b0;
    chk("seqA_busy", 25'(busy), 25'(1));
    for (int n = 2; n <= 10; n++) begin
      start   = (n == 5);
      stage   = (n == 5) ? 2'd3 : 2'd1;
      addr_nd = (n == 6);
      addr    = 3'd3;
      tick;
      if (n >= 3) begin
        chk($sformatf("seqA_out%0d", n - 3), {tf_nd, tf_out},
            {1'b1, ((n - 3) % 2 == 1) ? tf(0, -1024) : tf(1024, 0)});
        chk($sformatf("seqA_done%0d", n - 3), {busy, done}, {24'd0, 1'b1, (n == 10)});
      end
    end

    // back-to-back start in the done cycle: stage 2, inverse
    start = 1'b1; stage = 2'd2; inverse = 1'b1; addr_nd = 1'b0;
    tick;
    start = 1'b0; inverse = 1'b0;
    chk("seqB_busy", {busy, tf_nd}, 25'b10);
    for (int n = 12; n <= 20; n++) begin
      tick;
      if (n >= 13) begin
        case ((n - 13) % 4)
          0: chk($sformatf("seqB_out%0d", n - 13), {tf_nd, tf_out}, {1'b1, tf(1024, 0)});
          1: chk($sformatf("seqB_out%0d", n - 13), {tf_nd, tf_out}, {1'b1, tf(724, 724)});
          2: chk($sformatf("seqB_out%0d", n - 13), {tf_nd, tf_out}, {1'b1, tf(0, 1024)});
          default: chk($sformatf("seqB_out%0d", n - 13), {tf_nd, tf_out}, {1'b1, tf(-724, 724)});
        endcase
        chk($sformatf("seqB_done%0d", n - 13), 25'(done), 25'(n == 20));
      end
    end
    tick;
    chk("seqB_idle", {busy, done, tf_nd}, 25'b000);

    // stage 3 with colliding addr_nd; abort by reset after 3 outputs
    start = 1'b1; stage = 2'd3; addr_nd = 1'b1; addr = 3'd7;
    tick;
    start = 1'b0; addr_nd = 1'b0;
    chk("seqC_busy", 25'(busy), 25'(1));
    tick;
    chk("seqC_drop", 25'(tf_nd), 25'(0));
    tick;
    chk("seqC_out0", {tf_nd, tf_out}, {1'b1, tf(1024, 0)});
    tick;
    chk("seqC_out1", {tf_nd, tf_out}, {1'b1, tf(946, -392)});
    tick;
    chk("seqC_out2", {tf_nd, tf_out}, {1'b1, tf(724, -724)});
`else
    // start and stage have no effect without the sequencer
    start = 1'b1; stage = 2'd1; addr_nd = 1'b0;
    tick;
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick;
      seen = seen | tf_nd | busy | done;
    end
    chk("noseq_start", 25'(seen), 25'(0));
    start = 1'b1; addr = 3'd6; addr_nd = 1'b1;
    tick;
    start = 1'b0; addr_nd = 1'b0;
    tick;
    chk("noseq_addr6", {tf_nd, tf_out}, {1'b1, tf(-724, -724)});
    tick;

    // stream, then abort by reset after 3 outputs
    for (int k = 0; k < 4; k++) begin
      addr = 3'(k); addr_nd = 1'b1;
      tick;
    end
    addr = 3'd4;
    chk("abort_out2", {tf_nd, tf_out}, {1'b1, tf(724, -724)});
`endif

    #2 rst_n = 1'b0;
    #1;
    chk("abort_tf_out", 25'(tf_out), 25'(0));
    chk("abort_nd", {busy, done, tf_nd}, 25'b000);
    addr_nd = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick;
      seen = seen | tf_nd | done | busy;
    end
    chk("no_stale", 25'(seen), 25'(0));
    addr = 3'd3; addr_nd = 1'b1;
    tick;
    addr_nd = 1'b0;
    tick;
    chk("post_rst_a3", {tf_nd, tf_out}, {1'b1, tf(392, -946)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
